// File: rtl/owner_cash_retrieve.sv
// Owner-mode cash retrieval unit: accumulates customer deposits and, on owner
// request, drains the accumulator into a saturating retrieved-total register.
module owner_cash_retrieve #(
  parameter int ACC_W   = 5,
  parameter int TOTAL_W = 7,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               deposit_valid,
  input  logic [ACC_W-1:0]   deposit_amt,
  input  logic               retrieve_req,
  input  logic               clear_total,
  output logic               redLight,
  output logic [ACC_W-1:0]   machineAcc_out,
  output logic [TOTAL_W-1:0] totalMoneyRetrieve_out,
  output logic               retrieve_done,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0]   ACC_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;
  localparam logic [ACC_W-1:0]   STEP_V    = ACC_W'(STEP);

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc_nx;
  logic [TOTAL_W-1:0] total_nx;
  logic               ovf_nx;
  logic               done_nx;

  logic [ACC_W:0]     dep_sum;
  logic [ACC_W-1:0]   mv;
  logic [TOTAL_W:0]   tot_sum;

  // Sums carry one extra bit so a set MSB means the destination would clip.
  assign dep_sum = {1'b0, machineAcc_out} + {1'b0, deposit_amt};
  assign mv      = (machineAcc_out < STEP_V) ? machineAcc_out : STEP_V;
  assign tot_sum = {1'b0, totalMoneyRetrieve_out} + (TOTAL_W+1)'(mv);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    acc_nx   = machineAcc_out;
    total_nx = totalMoneyRetrieve_out;
    ovf_nx   = overflow;
    done_nx  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!mode) begin
          if (deposit_valid) begin
            if (dep_sum[ACC_W]) begin
              acc_nx = ACC_MAX;
              ovf_nx = 1'b1;
            end else begin
              acc_nx = dep_sum[ACC_W-1:0];
            end
          end
        end else if (retrieve_req) begin
          if (machineAcc_out == '0) done_nx  = 1'b1;
          else                      state_nx = DRAIN;
        end else if (clear_total) begin
          total_nx = '0;
          ovf_nx   = 1'b0;
        end
      end

      DRAIN: begin
        // Leaving owner mode aborts without performing this cycle's transfer.
        if (!mode) begin
          state_nx = IDLE;
        end else begin
          acc_nx = machineAcc_out - mv;
          if (tot_sum[TOTAL_W]) begin
            total_nx = TOTAL_MAX;
            ovf_nx   = 1'b1;
          end else begin
            total_nx = tot_sum[TOTAL_W-1:0];
          end
          if (acc_nx == '0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end
        end
      end

      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state and outputs are registered with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      redLight               <= 1'b0;
      machineAcc_out         <= '0;
      totalMoneyRetrieve_out <= '0;
      retrieve_done          <= 1'b0;
      overflow               <= 1'b0;
    end else begin
      state                  <= state_nx;
      redLight               <= (state_nx != IDLE);
      machineAcc_out         <= acc_nx;
      totalMoneyRetrieve_out <= total_nx;
      retrieve_done          <= done_nx;
      overflow               <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_owner_cash_retrieve.sv
// Bench for owner_cash_retrieve: STEP=1 and STEP=4 instances share stimulus and
// are compared against an integer-arithmetic reference model of the machine.
module tb_owner_cash_retrieve;

  localparam int ACC_MAX   = 31;
  localparam int TOTAL_MAX = 127;

  typedef struct {
    int acc;
    int total;
    bit ovf;
    bit busy;   // draining money
    bit fin;    // finished, done pulse showing
    bit done;
  } model_t;

  model_t m [2];

  logic       clk = 1'b0;
  logic       rst, mode, dv, req, clr;
  logic [4:0] amt;
  logic       red [2];
  logic       done [2];
  logic       ovf [2];
  logic [4:0] acc_o [2];
  logic [6:0] tot_o [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  owner_cash_retrieve #(.ACC_W(5), .TOTAL_W(7), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .mode(mode), .deposit_valid(dv), .deposit_amt(amt),
    .retrieve_req(req), .clear_total(clr), .redLight(red[0]),
    .machineAcc_out(acc_o[0]), .totalMoneyRetrieve_out(tot_o[0]),
    .retrieve_done(done[0]), .overflow(ovf[0])
  );

  owner_cash_retrieve #(.ACC_W(5), .TOTAL_W(7), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .mode(mode), .deposit_valid(dv), .deposit_amt(amt),
    .retrieve_req(req), .clear_total(clr), .redLight(red[1]),
    .machineAcc_out(acc_o[1]), .totalMoneyRetrieve_out(tot_o[1]),
    .retrieve_done(done[1]), .overflow(ovf[1])
  );

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].acc = 0; m[i].total = 0; m[i].ovf = 0;
      m[i].busy = 0; m[i].fin = 0; m[i].done = 0;
    end
  endtask

  // One clock edge of the machine, from the behavioural rules.
  task automatic model_edge();
    int mv;
    for (int i = 0; i < 2; i++) begin
      m[i].done = 0;
      if (m[i].busy) begin
        if (!mode) begin
          m[i].busy = 0;
        end else begin
          mv = (m[i].acc < step_of(i)) ? m[i].acc : step_of(i);
          m[i].acc   -= mv;
          m[i].total += mv;
          if (m[i].total > TOTAL_MAX) begin
            m[i].total = TOTAL_MAX;
            m[i].ovf   = 1;
          end
          if (m[i].acc == 0) begin
            m[i].busy = 0; m[i].fin = 1; m[i].done = 1;
          end
        end
      end else if (m[i].fin) begin
        m[i].fin = 0;
      end else if (!mode) begin
        if (dv) begin
          m[i].acc += int'(amt);
          if (m[i].acc > ACC_MAX) begin
            m[i].acc = ACC_MAX;
            m[i].ovf = 1;
          end
        end
      end else if (req) begin
        if (m[i].acc == 0) m[i].done = 1;
        else               m[i].busy = 1;
      end else if (clr) begin
        m[i].total = 0;
        m[i].ovf   = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic deposit(input int a);
    mode = 1'b0; dv = 1'b1; amt = 5'(a);
    tick();
    dv = 1'b0;
  endtask

  task automatic clear_totals();
    mode = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain_full();
    int k;
    mode = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (!red[0] && !red[1]) break;
      tick();
    end
    vectors++;
    if (k >= 40) begin
      miscompares++;
      $display("FAIL drain_timeout: redLight still {%b,%b} after 40 cycles, required 0", red[0], red[1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; dv = 1'b0; amt = '0; req = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({red[i], done[i], ovf[i], acc_o[i], tot_o[i]} !== 15'd0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got %h, required 0", i, {red[i], done[i], ovf[i], acc_o[i], tot_o[i]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_deposit();
    deposit(3);
    deposit(3);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (acc_o[i] !== 5'd6 || ovf[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL deposit_3_3[%0d]: acc=%0d ovf=%b, required acc=6 ovf=0", i, acc_o[i], ovf[i]);
      end
    end
  endtask

  task automatic test_drain();
    int red_cnt [2];
    int done_cnt [2];
    int done_at [2];
    bit red_first [2];
    int exp_n;
    for (int i = 0; i < 2; i++) begin
      red_cnt[i] = 0; done_cnt[i] = 0; done_at[i] = 0;
    end
    mode = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (c == 1) red_first[i] = red[i];
        if (red[i]) red_cnt[i]++;
        if (done[i]) begin done_cnt[i]++; done_at[i] = c; end
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      exp_n = (6 + step_of(i) - 1) / step_of(i) + 1;
      vectors++;
      if (red_first[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_latency[%0d]: redLight=%b one cycle after request, required 1", i, red_first[i]);
      end
      vectors++;
      if (red_cnt[i] != exp_n) begin
        miscompares++;
        $display("FAIL drain_red_cycles[%0d]: got %0d, required %0d", i, red_cnt[i], exp_n);
      end
      vectors++;
      if (done_cnt[i] != 1 || done_at[i] != exp_n) begin
        miscompares++;
        $display("FAIL drain_done[%0d]: %0d pulses last at cycle %0d, required 1 at cycle %0d", i, done_cnt[i], done_at[i], exp_n);
      end
      vectors++;
      if (tot_o[i] !== 7'd6 || acc_o[i] !== 5'd0) begin
        miscompares++;
        $display("FAIL drain_result[%0d]: total=%0d acc=%0d, required total=6 acc=0", i, tot_o[i], acc_o[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_totals();
    deposit(20);
    deposit(20);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (acc_o[i] !== 5'd31 || ovf[i] !== 1'b1) begin
        miscompares++;
        $display("FAIL acc_clip[%0d]: acc=%0d ovf=%b, required acc=31 ovf=1", i, acc_o[i], ovf[i]);
      end
    end
    clear_totals();
    drain_full();
    for (int r = 0; r < 3; r++) begin
      deposit(31);
      drain_full();
    end
    deposit(1);
    drain_full();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (tot_o[i] !== 7'd125 || ovf[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL total_125[%0d]: total=%0d ovf=%b, required total=125 ovf=0", i, tot_o[i], ovf[i]);
      end
    end
    deposit(6);
    drain_full();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (tot_o[i] !== 7'd127 || ovf[i] !== 1'b1 || acc_o[i] !== 5'd0) begin
        miscompares++;
        $display("FAIL total_clip[%0d]: total=%0d ovf=%b acc=%0d, required 127/1/0", i, tot_o[i], ovf[i], acc_o[i]);
      end
    end
    clear_totals();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (tot_o[i] !== 7'd0 || ovf[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL clear_total[%0d]: total=%0d ovf=%b, required 0/0", i, tot_o[i], ovf[i]);
      end
    end
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    deposit(6);
    mode = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) mode = 1'b0;
      tick();
      if (done[0]) done_seen++;
    end
    vectors++;
    if (acc_o[0] !== 5'd4 || tot_o[0] !== 7'd2 || red[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state: acc=%0d total=%0d red=%b, required acc=4 total=2 red=0", acc_o[0], tot_o[0], red[0]);
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", done_seen);
    end
    vectors++;
    if (acc_o[1] !== 5'(m[1].acc) || tot_o[1] !== 7'(m[1].total)) begin
      miscompares++;
      $display("FAIL abort_step4: acc=%0d total=%0d, required acc=%0d total=%0d", acc_o[1], tot_o[1], m[1].acc, m[1].total);
    end
  endtask

  task automatic test_empty_request();
    logic [6:0] saved [2];
    drain_full();
    for (int i = 0; i < 2; i++) saved[i] = tot_o[i];
    mode = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (done[i] !== 1'b1 || red[i] !== 1'b0 || tot_o[i] !== saved[i]) begin
        miscompares++;
        $display("FAIL empty_req[%0d]: done=%b red=%b total=%0d, required 1/0/%0d", i, done[i], red[i], tot_o[i], saved[i]);
      end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (done[i] !== 1'b0 || red[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL empty_req_pulse[%0d]: done=%b red=%b next cycle, required 0/0", i, done[i], red[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    deposit(10);
    mode = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({red[i], done[i], ovf[i], acc_o[i], tot_o[i]} !== 15'd0) begin
        miscompares++;
        $display("FAIL async_reset[%0d]: got %h before clock edge, required 0", i, {red[i], done[i], ovf[i], acc_o[i], tot_o[i]});
      end
    end
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [14:0] exp_v, got_v;
    mode = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) mode = ~mode;
      dv  = 1'($urandom_range(1));
      amt = 5'($urandom);
      req = ($urandom_range(3) == 0);
      clr = ($urandom_range(7) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        exp_v = {m[i].busy | m[i].fin, m[i].done, m[i].ovf, 5'(m[i].acc), 7'(m[i].total)};
        got_v = {red[i], done[i], ovf[i], acc_o[i], tot_o[i]};
        vectors++;
        if (got_v !== exp_v) begin
          miscompares++;
          $display("FAIL random[%0d] cycle %0d: {red,done,ovf,acc,total} got %b, required %b", i, c, got_v, exp_v);
        end
      end
    end
    dv = 1'b0; req = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_deposit();
    test_drain();
    test_saturation();
    test_abort();
    test_empty_request();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
